sll_multicycle: RTL and testbench



---
 rtl/shift_pkg.sv | 31 +++
 rtl/sll_stage.sv | 14 +
 rtl/sll_multicycle.sv | 126 ++++++++++++
 tb/tb_sll_multicycle.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types, widths and helpers for the multi-cycle logical left shifter.
package shift_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned NUM_STAGES = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic int unsigned stage_dist(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

    // Highest set bit of amt strictly below 'below'; bit 3 of the result flags that one exists.
    function automatic logic [3:0] next_set_bit(input logic [SHAMT_W-1:0] amt,
                                                input int unsigned below);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if ((i < int'(below)) && amt[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sll_stage.sv
// One power-of-two left-shift stage; passes data through when not enabled.
module sll_stage
    import shift_pkg::*;
#(
    parameter int unsigned Dist = 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              ena_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = ena_i ? (data_i << Dist) : data_i;

endmodule

// File: rtl/sll_multicycle.sv
// Multi-cycle logical left shifter, one power-of-two stage per clock (16, 8, 4, 2, 1).
// Define SLL_EARLY_EXIT_EN to skip stages whose shift-amount bit is clear.
module sll_multicycle
    import shift_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shiftamt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  data_o
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [2:0]         idx_q, idx_d;

    logic [DATA_W-1:0]  stage_out [NUM_STAGES];
    logic [DATA_W-1:0]  stage_sel;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        sll_stage #(
            .Dist(stage_dist(g))
        ) u_stage (
            .data_i(work_q),
            .ena_i (amt_q[g]),
            .data_o(stage_out[g])
        );
    end

    always_comb begin
        stage_sel = work_q;
        case (idx_q)
            3'd0:    stage_sel = stage_out[0];
            3'd1:    stage_sel = stage_out[1];
            3'd2:    stage_sel = stage_out[2];
            3'd3:    stage_sel = stage_out[3];
            3'd4:    stage_sel = stage_out[4];
            default: stage_sel = work_q;
        endcase
    end

    always_comb begin
`ifdef SLL_EARLY_EXIT_EN
        logic [3:0] nxt;
        nxt = 4'b0;
`endif
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        idx_d   = idx_q;
        // Flush wins over both accept and result handshake; datapath is left untouched.
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        work_d = data_i;
                        amt_d  = shiftamt_i;
`ifdef SLL_EARLY_EXIT_EN
                        nxt = next_set_bit(shiftamt_i, NUM_STAGES);
                        if (nxt[3]) begin
                            idx_d   = nxt[2:0];
                            state_d = SHIFT;
                        end else begin
                            idx_d   = 3'd0;
                            state_d = DONE;
                        end
`else
                        idx_d   = 3'd4;
                        state_d = SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    work_d = stage_sel;
`ifdef SLL_EARLY_EXIT_EN
                    nxt = next_set_bit(amt_q, 32'(idx_q));
                    if (nxt[3]) begin
                        idx_d = nxt[2:0];
                    end else begin
                        state_d = DONE;
                    end
`else
                    if (idx_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !reset;
    assign out_valid_o = (state_q == DONE);
    assign data_o      = work_q;

endmodule

// File: tb/tb_sll_multicycle.sv
// Directed self-checking bench for sll_multicycle (either SLL_EARLY_EXIT_EN build).
module tb_sll_multicycle;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic [4:0]  shiftamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    sll_multicycle u_dut (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .data_i     (data_in),
        .shiftamt_i (shiftamt),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .data_o     (data_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [4:0] amt);
`ifdef SLL_EARLY_EXIT_EN
        return $countones(amt);
`else
        return 5;
`endif
    endfunction

    // Present one operand, accept it at E0, return edges after E0 until out_valid (99 on timeout).
    task automatic start_op(input logic [31:0] d, input logic [4:0] a, output int lat);
        data_in  = d;
        shiftamt = a;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        data_in  = '0;
        shiftamt = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " valid_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, " ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] a,
                          input logic [31:0] exp);
        int lat;
        start_op(d, a, lat);
        check_eq({tag, " data"}, data_out, exp);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_latency(a)));
        finish_op(tag);
    endtask

    initial begin
        int lat;
        #2;
        check_eq("rst in_ready", 32'(in_ready), 32'd0);
        check_eq("rst out_valid", 32'(out_valid), 32'd0);
        check_eq("rst data_out", data_out, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("post-rst in_ready", 32'(in_ready), 32'd1);

        run_op("sll31", 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("sll4", 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0);
        run_op("sll16", 32'h1234_5678, 5'd16, 32'h5678_0000);
        run_op("sll0", 32'h8000_0001, 5'd0, 32'h8000_0001);
        run_op("sll13", 32'hA5A5_A5A5, 5'd13, 32'hB4B4_A000);

        // Backpressure: result and flags hold, and a new operand is ignored.
        start_op(32'h0000_0003, 5'd5, lat);
        check_eq("bp latency", 32'(lat), 32'(exp_latency(5'd5)));
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                data_in  = 32'hDEAD_BEEF;
                shiftamt = 5'd1;
            end
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            check_eq("bp out_valid", 32'(out_valid), 32'd1);
            check_eq("bp data", data_out, 32'h0000_0060);
            check_eq("bp in_ready", 32'(in_ready), 32'd0);
        end
        finish_op("bp");

        // Flush sampled at E2 of an in-flight shift.
        data_in  = 32'h0000_0001;
        shiftamt = 5'd31;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check_eq("flush in_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) lat++;
        end
        check_eq("flush no valid", 32'(lat), 32'd0);
        run_op("after flush", 32'h0000_00FF, 5'd8, 32'h0000_FF00);

        // Flush beats in_valid in IDLE: nothing is accepted.
        data_in  = 32'h0000_0007;
        shiftamt = 5'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush idle ready", 32'(in_ready), 32'd1);
        check_eq("flush idle data", data_out, 32'h0000_FF00);

        // Asynchronous reset in the middle of a shift.
        data_in  = 32'h0000_0001;
        shiftamt = 5'd31;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst out_valid", 32'(out_valid), 32'd0);
        check_eq("arst data", data_out, 32'd0);
        check_eq("arst in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("arst release ready", 32'(in_ready), 32'd1);
        check_eq("arst release valid", 32'(out_valid), 32'd0);
        run_op("after rst", 32'h0000_0003, 5'd30, 32'hC000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
